// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - runtime-programmable integer clock divider with registered square-wave output
// Optional CLK_DIVIDER_TICK_EN adds a one-cycle `tick` strobe coincident with each clk_out rise.
module clk_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_div,
  output logic             clk_out
`ifdef CLK_DIVIDER_TICK_EN
  ,
  output logic             tick
`endif
);

  logic             r_clk_out;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_n_q;
  logic             r_idle;

  logic             w_clk_out_nx;
  logic [DIV_W-1:0] w_cnt_nx;
  logic [DIV_W-1:0] w_n_q_nx;
  logic             w_idle_nx;

  logic             w_div_ok;
  logic [DIV_W-1:0] w_l_new_m1;
  logic [DIV_W-1:0] w_h_q_m1;
  logic             w_rise;

  // Low phase takes the extra cycle on odd ratios, so L = N - floor(N/2).
  assign w_div_ok   = (clk_div > DIV_W'(1));
  assign w_l_new_m1 = clk_div - (clk_div >> 1) - DIV_W'(1);
  assign w_h_q_m1   = (r_n_q >> 1) - DIV_W'(1);
  assign w_rise     = !r_idle && (r_cnt == '0) && !r_clk_out;

  always_comb begin
    w_clk_out_nx = r_clk_out;
    w_cnt_nx     = r_cnt;
    w_n_q_nx     = r_n_q;
    w_idle_nx    = r_idle;
    if (r_idle) begin
      w_clk_out_nx = 1'b0;
      if (w_div_ok) begin
        w_n_q_nx  = clk_div;
        w_idle_nx = 1'b0;
        w_cnt_nx  = w_l_new_m1;
      end
    end else if (r_cnt != '0) begin
      w_cnt_nx = r_cnt - DIV_W'(1);
    end else if (!r_clk_out) begin
      w_clk_out_nx = 1'b1;
      w_cnt_nx     = w_h_q_m1;
    end else begin
      // Period boundary: the only point where a new ratio takes effect.
      w_clk_out_nx = 1'b0;
      if (w_div_ok) begin
        w_n_q_nx = clk_div;
        w_cnt_nx = w_l_new_m1;
      end else begin
        w_idle_nx = 1'b1;
        w_cnt_nx  = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_clk_out <= 1'b0;
      r_cnt     <= '0;
      r_n_q     <= '0;
      r_idle    <= 1'b1;
    end else begin
      r_clk_out <= w_clk_out_nx;
      r_cnt     <= w_cnt_nx;
      r_n_q     <= w_n_q_nx;
      r_idle    <= w_idle_nx;
    end
  end

  assign clk_out = r_clk_out;

`ifdef CLK_DIVIDER_TICK_EN
  logic r_tick;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_rise;
    end
  end

  assign tick = r_tick;
`else
  logic w_unused_rise;
  assign w_unused_rise = w_rise;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - directed self-checking bench for clk_divider (optionally with CLK_DIVIDER_TICK_EN)
module tb_clk_divider;

  logic        clk_in;
  logic        rst;
  logic [15:0] clk_div;
  logic        clk_out;
`ifdef CLK_DIVIDER_TICK_EN
  logic        tick;
`endif

  int n_cmp = 0;
  int n_err = 0;

  clk_divider #(.DIV_W(16)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .clk_div(clk_div),
    .clk_out(clk_out)
`ifdef CLK_DIVIDER_TICK_EN
    ,
    .tick   (tick)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Holds rst for ncyc edges with ratio n applied; the next edge is edge 1.
  task automatic apply_reset(input int ncyc, input logic [15:0] n);
    rst     = 1'b1;
    clk_div = n;
    repeat (ncyc) step();
    rst = 1'b0;
  endtask

  // Runs ncyc edges, reporting first rise edge, rise count, and runs that
  // deviate from the expected high/low lengths (initial low run excluded).
  task automatic measure(input int ncyc, input int exp_h, input int exp_l,
                         output int first_rise, output int rises,
                         output int bad_hi, output int bad_lo,
                         output int ticks, output int tick_bad);
    logic prev, cur;
    int   run;
    first_rise = 0; rises = 0; bad_hi = 0; bad_lo = 0; ticks = 0; tick_bad = 0;
    prev = clk_out;
    run  = 0;
    for (int e = 1; e <= ncyc; e++) begin
      step();
      cur = clk_out;
`ifdef CLK_DIVIDER_TICK_EN
      if (tick === 1'b1) ticks++;
      if (tick !== (cur && !prev)) tick_bad++;
`endif
      if (cur !== prev) begin
        if (cur && !prev) begin
          rises++;
          if (first_rise == 0) first_rise = e;
          else if (run != exp_l) bad_lo++;
        end else if (run != exp_h) begin
          bad_hi++;
        end
        run = 1;
      end else begin
        run++;
      end
      prev = cur;
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b1;
    clk_div = 16'd1000;
    for (int i = 0; i < 5; i++) begin
      step();
      if (clk_out !== 1'b0) bad++;
`ifdef CLK_DIVIDER_TICK_EN
      if (tick !== 1'b0) bad++;
`endif
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL reset_low: %0d nonzero samples, want 0", bad);
    end
  endtask

  task automatic test_div1000();
    int fr, ri, bh, bl, tk, tb;
    apply_reset(5, 16'd1000);
    measure(8000, 500, 500, fr, ri, bh, bl, tk, tb);
    n_cmp++; if (fr !== 501) begin n_err++; $display("FAIL n1000_first_rise: got %0d want 501", fr); end
    n_cmp++; if (ri !== 8)   begin n_err++; $display("FAIL n1000_periods: got %0d want 8", ri); end
    n_cmp++; if (bh !== 0)   begin n_err++; $display("FAIL n1000_high_len: %0d bad runs want 0", bh); end
    n_cmp++; if (bl !== 0)   begin n_err++; $display("FAIL n1000_low_len: %0d bad runs want 0", bl); end
`ifdef CLK_DIVIDER_TICK_EN
    n_cmp++; if (tk !== 8)   begin n_err++; $display("FAIL n1000_tick_count: got %0d want 8", tk); end
    n_cmp++; if (tb !== 0)   begin n_err++; $display("FAIL n1000_tick_align: %0d misaligned want 0", tb); end
`endif
  endtask

  task automatic test_div5();
    int fr, ri, bh, bl, tk, tb;
    apply_reset(3, 16'd5);
    measure(25, 2, 3, fr, ri, bh, bl, tk, tb);
    n_cmp++; if (fr !== 4) begin n_err++; $display("FAIL n5_first_rise: got %0d want 4", fr); end
    n_cmp++; if (ri !== 5) begin n_err++; $display("FAIL n5_rises: got %0d want 5", ri); end
    n_cmp++; if (bh !== 0) begin n_err++; $display("FAIL n5_high_len: %0d bad runs want 0", bh); end
    n_cmp++; if (bl !== 0) begin n_err++; $display("FAIL n5_low_len: %0d bad runs want 0", bl); end
  endtask

  task automatic test_div2();
    int fr, ri, bh, bl, tk, tb;
    apply_reset(3, 16'd2);
    measure(10, 1, 1, fr, ri, bh, bl, tk, tb);
    n_cmp++; if (fr !== 2) begin n_err++; $display("FAIL n2_first_rise: got %0d want 2", fr); end
    n_cmp++; if (ri !== 5) begin n_err++; $display("FAIL n2_rises: got %0d want 5", ri); end
    n_cmp++; if ((bh + bl) !== 0) begin n_err++; $display("FAIL n2_toggle: %0d bad runs want 0", bh + bl); end
  endtask

  task automatic test_idle_then_start();
    int fr, ri, bh, bl, tk, tb;
    apply_reset(3, 16'd0);
    measure(10, 0, 0, fr, ri, bh, bl, tk, tb);
    n_cmp++; if (ri !== 0) begin n_err++; $display("FAIL n0_idle: got %0d rises want 0", ri); end
    clk_div = 16'd1;
    measure(10, 0, 0, fr, ri, bh, bl, tk, tb);
    n_cmp++; if (ri !== 0) begin n_err++; $display("FAIL n1_idle: got %0d rises want 0", ri); end
    clk_div = 16'd4;
    measure(6, 2, 2, fr, ri, bh, bl, tk, tb);
    n_cmp++; if (fr !== 3) begin n_err++; $display("FAIL n4_start_rise: got %0d want 3", fr); end
  endtask

  task automatic test_ratio_change();
    logic [20:1] got;
    logic [20:1] want;
    // Edges 1..20: 5 low, 5 high at N=10, then 2/2 at N=4.
    want = 20'b00_11_00_11_00_11111_00000;
    apply_reset(3, 16'd10);
    for (int e = 1; e <= 20; e++) begin
      step();
      got[e] = clk_out;
      if (e == 8) clk_div = 16'd4;
    end
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL ratio_change: got %b want %b", got, want);
    end
  endtask

  task automatic test_rst_mid();
    int fr, ri, bh, bl, tk, tb;
    logic seen_hi;
    apply_reset(3, 16'd10);
    repeat (7) step();
    seen_hi = clk_out;
    n_cmp++; if (seen_hi !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_high: got %b want 1", seen_hi); end
    rst = 1'b1;
    step();
    n_cmp++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_low: got %b want 0", clk_out); end
`ifdef CLK_DIVIDER_TICK_EN
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_mid_tick: got %b want 0", tick); end
`endif
    step();
    rst = 1'b0;
    measure(12, 5, 5, fr, ri, bh, bl, tk, tb);
    n_cmp++; if (fr !== 6) begin n_err++; $display("FAIL rst_mid_relaunch: got %0d want 6", fr); end
  endtask

  initial begin
    rst     = 1'b1;
    clk_div = 16'd0;
    test_reset();
    test_div1000();
    test_div5();
    test_div2();
    test_idle_then_start();
    test_ratio_change();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
